// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- round-robin arbiter sharing one UART transmitter among
// NREQ byte requesters.
//
// Optional feature macro: UART_ARB_TMO_EN
//   When defined, a watchdog counts cycles spent in WAIT_BUSY. If the
//   transmitter never raises tx_busy within BUSY_TMO cycles, tmo_err pulses
//   and the arbiter returns to IDLE. Without the macro, WAIT_BUSY waits
//   indefinitely and tmo_err is tied low.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NREQ]     per-requester byte pending, held until req_ack
//   req_data   in   [8*NREQ]   byte of requester i on bits [8*i+7:8*i]
//   req_ack    out  [NREQ]     one-cycle pulse, byte handed to transmitter
//   pi_data    out  [8]        byte to transmitter, held until next grant
//   pi_flag    out             one-cycle transmit strobe
//   tx_busy    in              transmitter frame in progress
//   grant_id   out  [GID_W]    last/current granted requester
//   arb_busy   out             arbiter not in IDLE
//   tmo_err    out             one-cycle pulse on busy timeout
module uart_tx_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned GID_W    = 2,
  parameter int unsigned BUSY_TMO = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ack,
  output logic [7:0]          pi_data,
  output logic                pi_flag,
  input  logic                tx_busy,
  output logic [GID_W-1:0]    grant_id,
  output logic                arb_busy,
  output logic                tmo_err
);

  if ((GID_W != $clog2(NREQ)) || (BUSY_TMO == 0)) begin : g_cfg_err
    $error("uart_tx_arb: GID_W must equal clog2(NREQ) and BUSY_TMO must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [GID_W-1:0] gid_q, gid_d;
  logic [7:0]       data_q, data_d;

  // Round-robin pick: first requester at or after ptr_q; if none exists
  // above the pointer, wrap to the lowest-indexed active requester.
  logic             hit_hi, hit_lo;
  logic [GID_W-1:0] sel_hi, sel_lo, sel;
  logic [7:0]       sel_byte;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hit_lo) begin
        hit_lo = 1'b1;
        sel_lo = GID_W'(i);
      end
      if (req_valid[i] && !hit_hi && (GID_W'(i) >= ptr_q)) begin
        hit_hi = 1'b1;
        sel_hi = GID_W'(i);
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
    sel_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GID_W'(i) == sel) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TMO_EN
  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  // Counter holds the number of completed WAIT_BUSY cycles; the hit fires
  // during the BUSY_TMO-th cycle in which tx_busy is still low.
  assign tmo_hit = (state_q == WAIT_BUSY) && !tx_busy &&
                   (tmo_cnt_q == TMO_W'(BUSY_TMO - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == WAIT_BUSY) && !tx_busy) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (!tx_busy && (|req_valid)) begin
          gid_d   = sel;
          data_d  = sel_byte;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (gid_q == GID_W'(NREQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TMO_EN
        else if (tmo_hit) begin
          state_d = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pi_flag  = (state_q == ISSUE);
    arb_busy = (state_q != IDLE);
    req_ack  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ack[i] = (state_q == ISSUE) && (gid_q == GID_W'(i));
    end
`ifdef UART_ARB_TMO_EN
    tmo_err = tmo_hit;
`else
    tmo_err = 1'b0;
`endif
  end

  assign grant_id = gid_q;
  assign pi_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus a randomized
// phase, all compared against a queue-free arithmetic model of round-robin
// arbitration (pointer + modular search over the driven request vector).
module tb_uart_tx_arb;
  localparam int NREQ  = 4;
  localparam int GID_W = 2;
  localparam int TMO   = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                tx_busy = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ack;
  logic [8*NREQ-1:0]   req_data;
  logic [7:0]          pi_data;
  logic                pi_flag;
  logic [GID_W-1:0]    grant_id;
  logic                arb_busy;
  logic                tmo_err;

  logic [7:0] bytes [NREQ];
  int         ack_cnt [NREQ];
  int         vectors = 0;
  int         miscompares = 0;
  int         mdl_ptr = 0;
  logic [7:0] last_byte = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = bytes[i];
  end

  uart_tx_arb #(
    .NREQ(NREQ),
    .GID_W(GID_W),
    .BUSY_TMO(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .pi_data(pi_data),
    .pi_flag(pi_flag),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .tmo_err(tmo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge, with per-cycle invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("ack_onehot", $onehot0(req_ack), 1);
    chk("ack_vs_flag", |req_ack, pi_flag);
  endtask

  // Reference: first active requester at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Called in IDLE with a nonzero req_valid: the grant must appear one cycle later.
  task automatic issue(input string tag, input bit keep);
    int exp_id;
    exp_id = pick(req_valid, mdl_ptr);
    step();
    chk({tag, ".flag"}, pi_flag, 1);
    chk({tag, ".ack"}, req_ack, 1 << exp_id);
    chk({tag, ".gid"}, grant_id, exp_id);
    chk({tag, ".data"}, pi_data, bytes[exp_id]);
    chk({tag, ".busy"}, arb_busy, 1);
    last_byte = bytes[exp_id];
    ack_cnt[exp_id]++;
    mdl_ptr = (exp_id + 1) % NREQ;
    if (keep) bytes[exp_id] = 8'($urandom);
    else req_valid[exp_id] = 1'b0;
  endtask

  // Transmitter model: raise busy for n cycles after the strobe, then drop.
  task automatic finish_frame(input int n);
    step();
    chk("wb.flag", pi_flag, 0);
    chk("wb.hold", pi_data, last_byte);
    tx_busy = 1'b1;
    for (int c = 0; c < n; c++) begin
      step();
      chk("wd.flag", pi_flag, 0);
      chk("wd.busy", arb_busy, 1);
      chk("wd.hold", pi_data, last_byte);
    end
    tx_busy = 1'b0;
    step();
    chk("idle.busy", arb_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a3;
    logic [NREQ-1:0] pat;
    for (int i = 0; i < NREQ; i++) begin
      bytes[i]   = '0;
      ack_cnt[i] = 0;
    end

    // Asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst.flag", pi_flag, 0);
    chk("rst.ack", req_ack, 0);
    chk("rst.busy", arb_busy, 0);
    chk("rst.gid", grant_id, 0);
    chk("rst.data", pi_data, 0);
    chk("rst.tmo", tmo_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // No requests: nothing happens
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle.flag", pi_flag, 0);
      chk("idle.arb", arb_busy, 0);
    end

    // Round robin with all requesters continuously pending
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      issue("rr", 1'b1);
      chk("rr.order", grant_id, g % NREQ);
      finish_frame(10);
    end
    req_valid = '0;

    // Single request on requester 1
    bytes[1]  = 8'hA5;
    req_valid = 4'b0010;
    issue("single", 1'b0);
    chk("single.lit", pi_data, 8'hA5);
    chk("single.gid_lit", grant_id, 1);
    finish_frame(4);

    // Move pointer to 3, then wrap/skip with 0101
    bytes[2]  = 8'($urandom);
    req_valid = 4'b0100;
    issue("ptr3", 1'b0);
    finish_frame(2);
    a3 = ack_cnt[3];
    bytes[0]  = 8'($urandom);
    bytes[2]  = 8'($urandom);
    req_valid = 4'b0101;
    issue("wrap0", 1'b0);
    chk("wrap0.lit", grant_id, 0);
    finish_frame(3);
    issue("wrap2", 1'b0);
    chk("wrap2.lit", grant_id, 2);
    finish_frame(3);
    chk("wrap.no3", ack_cnt[3], a3);

    // Busy blocking in IDLE
    bytes[0]  = 8'($urandom);
    req_valid = 4'b0001;
    tx_busy   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("blk.flag", pi_flag, 0);
      chk("blk.arb", arb_busy, 0);
    end
    tx_busy = 1'b0;
    issue("blk", 1'b0);
    finish_frame(2);

    // Transmitter never responds
    bytes[0]  = 8'($urandom);
    req_valid = 4'b0001;
    issue("tmo", 1'b0);
`ifdef UART_ARB_TMO_EN
    for (int c = 1; c <= TMO; c++) begin
      step();
      chk("tmo.err", tmo_err, (c == TMO));
      chk("tmo.arb", arb_busy, 1);
    end
    step();
    chk("tmo.idle", arb_busy, 0);
    chk("tmo.clr", tmo_err, 0);
    bytes[1]  = 8'($urandom);
    req_valid = 4'b0010;
    issue("tmo_next", 1'b0);
    finish_frame(3);
`else
    for (int c = 1; c <= TMO + 4; c++) begin
      step();
      chk("notmo.err", tmo_err, 0);
      chk("notmo.arb", arb_busy, 1);
    end
    tx_busy = 1'b1;
    step();
    chk("notmo.wd", arb_busy, 1);
    tx_busy = 1'b0;
    step();
    chk("notmo.idle", arb_busy, 0);
`endif

    // Reset in WAIT_DONE with other requesters pending
    bytes[1]  = 8'($urandom);
    bytes[2]  = 8'($urandom);
    req_valid = 4'b0110;
    issue("pre_rst", 1'b0);
    step();
    tx_busy = 1'b1;
    step();
    chk("pre_rst.wd", arb_busy, 1);
    rst = 1'b1;
    #1;
    chk("mrst.flag", pi_flag, 0);
    chk("mrst.ack", req_ack, 0);
    chk("mrst.arb", arb_busy, 0);
    chk("mrst.gid", grant_id, 0);
    chk("mrst.data", pi_data, 0);
    chk("mrst.tmo", tmo_err, 0);
    @(posedge clk);
    #1;
    chk("mrst.hold_ack", req_ack, 0);
    rst       = 1'b0;
    tx_busy   = 1'b0;
    mdl_ptr   = 0;
    bytes[3]  = 8'($urandom);
    req_valid = 4'b1000;
    issue("post_rst", 1'b0);
    chk("post_rst.lit", grant_id, 3);
    finish_frame(3);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      pat = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (pat[i] && !req_valid[i]) bytes[i] = 8'($urandom);
      end
      req_valid = pat;
      if (pat == '0) begin
        step();
        chk("rnd.idle_flag", pi_flag, 0);
        chk("rnd.idle_arb", arb_busy, 0);
      end else begin
        issue("rnd", 1'($urandom_range(0, 1)));
        finish_frame(int'($urandom_range(1, 12)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
